// File: rtl/vga_fb_scanout.sv
// VGA 640x480 scan-out: raster counters, pixel-doubled frame-buffer read addressing,
// and a control delay line that keeps syncs aligned with the returned pixel data.
module vga_fb_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [16:0] fb_addr,
    output logic        fb_rd_en,
    input  logic [2:0]  fb_data,
    output logic [2:0]  rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        visible;
    logic        hs_now;
    logic        vs_now;
    logic        fs_now;
    logic [8:0]  x_pix;
    logic [8:0]  y_pix;
    logic [16:0] addr_calc;

    // Index 0 is the newest tap; index RD_LATENCY lines up with fb_data.
    logic [RD_LATENCY:0] vis_tap;
    logic [RD_LATENCY:0] hs_tap;
    logic [RD_LATENCY:0] vs_tap;
    logic [RD_LATENCY:0] fs_tap;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Each frame-buffer pixel covers a 2x2 block of screen pixels; row stride is 320 = 256 + 64.
    always_comb begin
        visible   = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
        hs_now    = !((h_cnt >= 10'(HS_FIRST)) && (h_cnt <= 10'(HS_LAST)));
        vs_now    = !((v_cnt >= 10'(VS_FIRST)) && (v_cnt <= 10'(VS_LAST)));
        fs_now    = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        x_pix     = h_cnt[9:1];
        y_pix     = v_cnt[9:1];
        addr_calc = ({8'd0, y_pix} << 8) + ({8'd0, y_pix} << 6) + {8'd0, x_pix};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
        end else begin
            fb_addr  <= visible ? addr_calc : 17'd0;
            fb_rd_en <= visible;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vis_tap <= '0;
            hs_tap  <= '1;
            vs_tap  <= '1;
            fs_tap  <= '0;
        end else begin
            vis_tap <= {vis_tap[RD_LATENCY-1:0], visible};
            hs_tap  <= {hs_tap[RD_LATENCY-1:0], hs_now};
            vs_tap  <= {vs_tap[RD_LATENCY-1:0], vs_now};
            fs_tap  <= {fs_tap[RD_LATENCY-1:0], fs_now};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb         <= 3'b000;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            rgb         <= vis_tap[RD_LATENCY] ? fb_data : 3'b000;
            hsync       <= hs_tap[RD_LATENCY];
            vsync       <= vs_tap[RD_LATENCY];
            frame_start <= fs_tap[RD_LATENCY];
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: two instances (read latency 1 and 3) with a short vertical
// raster, checked against a position-based reference model of the raster.
module tb_vga_fb_scanout;

    localparam int H_TOT  = 800;
    localparam int V_ACT  = 6;
    localparam int V_FPT  = 1;
    localparam int V_SY   = 2;
    localparam int V_BPT  = 1;
    localparam int V_TOT  = V_ACT + V_FPT + V_SY + V_BPT;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int LAT_A  = 3;
    localparam int LAT_B  = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] a_addr, b_addr;
    logic        a_rd_en, b_rd_en;
    logic [2:0]  a_data, b_data;
    logic [2:0]  a_rgb, b_rgb;
    logic        a_hsync, b_hsync, a_vsync, b_vsync, a_fs, b_fs;

    logic [2:0]  mem [0:76799];
    bit          force_white = 1'b0;
    logic [2:0]  a_q, b_q1, b_q2, b_q3;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clock = ~clock;

    vga_fb_scanout #(.V_ACTIVE(V_ACT), .V_FP(V_FPT), .V_SYNC(V_SY), .V_BP(V_BPT), .RD_LATENCY(1)) dut_a (
        .clock(clock), .reset(reset), .fb_addr(a_addr), .fb_rd_en(a_rd_en), .fb_data(a_data),
        .rgb(a_rgb), .hsync(a_hsync), .vsync(a_vsync), .frame_start(a_fs));

    vga_fb_scanout #(.V_ACTIVE(V_ACT), .V_FP(V_FPT), .V_SYNC(V_SY), .V_BP(V_BPT), .RD_LATENCY(3)) dut_b (
        .clock(clock), .reset(reset), .fb_addr(b_addr), .fb_rd_en(b_rd_en), .fb_data(b_data),
        .rgb(b_rgb), .hsync(b_hsync), .vsync(b_vsync), .frame_start(b_fs));

    function automatic logic [2:0] mem_read(logic [16:0] a);
        if (force_white) return 3'd7;
        if (a < 17'd76800) return mem[a];
        return 3'd0;
    endfunction

    // Synchronous-read memories with 1 and 3 clocks of latency
    always @(posedge clock) a_q <= mem_read(a_addr);
    always @(posedge clock) begin
        b_q1 <= mem_read(b_addr);
        b_q2 <= b_q1;
        b_q3 <= b_q2;
    end
    assign a_data = a_q;
    assign b_data = b_q3;

    // Clocks since the last reset edge; the counters hold raster position cyc
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    function automatic bit vis_at(int p);
        if (p < 0) return 1'b0;
        return ((p % H_TOT) < 640) && (((p / H_TOT) % V_TOT) < V_ACT);
    endfunction

    function automatic logic [16:0] addr_at(int p);
        if (!vis_at(p)) return 17'd0;
        return 17'((((p / H_TOT) % V_TOT) / 2) * 320 + (p % H_TOT) / 2);
    endfunction

    function automatic logic [2:0] rgb_at(int p);
        if (!vis_at(p)) return 3'd0;
        if (force_white) return 3'd7;
        return mem[addr_at(p)];
    endfunction

    function automatic bit hs_at(int p);
        if (p < 0) return 1'b1;
        return !(((p % H_TOT) >= 656) && ((p % H_TOT) < 752));
    endfunction

    function automatic bit vs_at(int p);
        int v;
        if (p < 0) return 1'b1;
        v = (p / H_TOT) % V_TOT;
        return !((v >= V_ACT + V_FPT) && (v < V_ACT + V_FPT + V_SY));
    endfunction

    function automatic bit fs_at(int p);
        return (p >= 0) && ((p % FRAME) == 0);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if ({a_addr, a_rd_en, a_rgb, a_hsync, a_vsync, a_fs} !== {17'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL reset_a @%0d: got %h, expected %h", i,
                         {a_addr, a_rd_en, a_rgb, a_hsync, a_vsync, a_fs}, {17'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0});
            end
            vectors++;
            if ({b_addr, b_rd_en, b_rgb, b_hsync, b_vsync, b_fs} !== {17'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL reset_b @%0d: got %h, expected %h", i,
                         {b_addr, b_rd_en, b_rgb, b_hsync, b_vsync, b_fs}, {17'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_first_line();
        int  fs_cyc = -1;
        int  hs_fall = -1;
        logic prev_hs = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clock);
            vectors++;
            if ({a_rgb, a_hsync, a_vsync, a_fs} !== {rgb_at(cyc - LAT_A), hs_at(cyc - LAT_A), vs_at(cyc - LAT_A), fs_at(cyc - LAT_A)}) begin
                miscompares++;
                $display("[TB] FAIL first_line_out @%0d: got %h, expected %h", cyc, {a_rgb, a_hsync, a_vsync, a_fs},
                         {rgb_at(cyc - LAT_A), hs_at(cyc - LAT_A), vs_at(cyc - LAT_A), fs_at(cyc - LAT_A)});
            end
            if (cyc >= LAT_A && cyc < LAT_A + 640) begin
                vectors++;
                if (a_rgb !== 3'(((cyc - LAT_A) / 2) % 8)) begin
                    miscompares++;
                    $display("[TB] FAIL first_line_pattern @%0d: got %0d, expected %0d", cyc, a_rgb, ((cyc - LAT_A) / 2) % 8);
                end
            end
            if (a_fs && fs_cyc < 0) fs_cyc = cyc;
            if (prev_hs && !a_hsync && hs_fall < 0) hs_fall = cyc;
            prev_hs = a_hsync;
        end
        vectors++;
        if (fs_cyc !== LAT_A) begin
            miscompares++;
            $display("[TB] FAIL first_frame_start: got %0d, expected %0d", fs_cyc, LAT_A);
        end
        vectors++;
        if (hs_fall - fs_cyc !== 656) begin
            miscompares++;
            $display("[TB] FAIL hsync_after_fs: got %0d, expected 656", hs_fall - fs_cyc);
        end
    endtask

    task automatic test_full_frame();
        int pos_tab [5] = '{1, 2, 639, 2 * H_TOT, (V_ACT - 1) * H_TOT + 639};
        int exp_tab [5] = '{0, 1, 319, 320, ((V_ACT - 1) / 2) * 320 + 319};
        bit hit [5] = '{default: 1'b0};
        int rd_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clock);
            rd_count += int'(a_rd_en);
            vectors++;
            if ({a_addr, a_rd_en} !== {addr_at(cyc - 1), vis_at(cyc - 1)}) begin
                miscompares++;
                $display("[TB] FAIL addr_a @%0d: got %h, expected %h", cyc, {a_addr, a_rd_en}, {addr_at(cyc - 1), vis_at(cyc - 1)});
            end
            vectors++;
            if ({b_addr, b_rd_en} !== {addr_at(cyc - 1), vis_at(cyc - 1)}) begin
                miscompares++;
                $display("[TB] FAIL addr_b @%0d: got %h, expected %h", cyc, {b_addr, b_rd_en}, {addr_at(cyc - 1), vis_at(cyc - 1)});
            end
            for (int t = 0; t < 5; t++) begin
                if ((cyc - 1) % FRAME == pos_tab[t]) begin
                    hit[t] = 1'b1;
                    vectors++;
                    if (a_addr !== 17'(exp_tab[t])) begin
                        miscompares++;
                        $display("[TB] FAIL addr_corner%0d: got %0d, expected %0d", t, a_addr, exp_tab[t]);
                    end
                end
            end
        end
        for (int t = 0; t < 5; t++) begin
            vectors++;
            if (!hit[t]) begin
                miscompares++;
                $display("[TB] FAIL addr_corner%0d_seen: got 0, expected 1", t);
            end
        end
        vectors++;
        if (rd_count !== 640 * V_ACT) begin
            miscompares++;
            $display("[TB] FAIL rd_en_count: got %0d, expected %0d", rd_count, 640 * V_ACT);
        end
    endtask

    task automatic test_rd_latency3();
        int fs_cyc = -1;
        for (int i = 0; i < 76800; i++) mem[i] = 3'($urandom_range(0, 7));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2 * H_TOT + 10; i++) begin
            @(negedge clock);
            if (b_fs && fs_cyc < 0) fs_cyc = cyc;
            vectors++;
            if ({b_rgb, b_hsync, b_vsync, b_fs} !== {rgb_at(cyc - LAT_B), hs_at(cyc - LAT_B), vs_at(cyc - LAT_B), fs_at(cyc - LAT_B)}) begin
                miscompares++;
                $display("[TB] FAIL lat3_out @%0d: got %h, expected %h", cyc, {b_rgb, b_hsync, b_vsync, b_fs},
                         {rgb_at(cyc - LAT_B), hs_at(cyc - LAT_B), vs_at(cyc - LAT_B), fs_at(cyc - LAT_B)});
            end
            vectors++;
            if ({a_rgb, a_hsync, a_vsync, a_fs} !== {rgb_at(cyc - LAT_A), hs_at(cyc - LAT_A), vs_at(cyc - LAT_A), fs_at(cyc - LAT_A)}) begin
                miscompares++;
                $display("[TB] FAIL lat1_out @%0d: got %h, expected %h", cyc, {a_rgb, a_hsync, a_vsync, a_fs},
                         {rgb_at(cyc - LAT_A), hs_at(cyc - LAT_A), vs_at(cyc - LAT_A), fs_at(cyc - LAT_A)});
            end
        end
        vectors++;
        if (fs_cyc !== LAT_B) begin
            miscompares++;
            $display("[TB] FAIL lat3_frame_start: got %0d, expected %0d", fs_cyc, LAT_B);
        end
    endtask

    task automatic test_sync_widths();
        int hs_run = 0, vs_run = 0, hs_last = -1, vs_last = -1, fs_last = -1;
        int vs_runs = 0, fs_periods = 0;
        bit hs_seen = 1'b0, vs_seen = 1'b0;
        logic hs_prev = a_hsync, vs_prev = a_vsync;
        for (int i = 0; i < 2 * FRAME + 100; i++) begin
            @(negedge clock);
            if (!a_hsync) hs_run++;
            if (!a_vsync) vs_run++;
            if (hs_prev && !a_hsync) begin
                if (hs_last >= 0) begin
                    vectors++;
                    if (cyc - hs_last !== H_TOT) begin
                        miscompares++;
                        $display("[TB] FAIL hsync_period: got %0d, expected %0d", cyc - hs_last, H_TOT);
                    end
                end
                hs_last = cyc; hs_seen = 1'b1; hs_run = 1;
            end
            if (!hs_prev && a_hsync && hs_seen) begin
                vectors++;
                if (hs_run !== 96) begin
                    miscompares++;
                    $display("[TB] FAIL hsync_width: got %0d, expected 96", hs_run);
                end
            end
            if (vs_prev && !a_vsync) begin
                if (vs_last >= 0) begin
                    vectors++;
                    if (cyc - vs_last !== FRAME) begin
                        miscompares++;
                        $display("[TB] FAIL vsync_period: got %0d, expected %0d", cyc - vs_last, FRAME);
                    end
                end
                vs_last = cyc; vs_seen = 1'b1; vs_run = 1;
            end
            if (!vs_prev && a_vsync && vs_seen) begin
                vs_runs++;
                vectors++;
                if (vs_run !== V_SY * H_TOT) begin
                    miscompares++;
                    $display("[TB] FAIL vsync_width: got %0d, expected %0d", vs_run, V_SY * H_TOT);
                end
            end
            if (a_fs) begin
                if (fs_last >= 0) begin
                    fs_periods++;
                    vectors++;
                    if (cyc - fs_last !== FRAME) begin
                        miscompares++;
                        $display("[TB] FAIL frame_start_period: got %0d, expected %0d", cyc - fs_last, FRAME);
                    end
                end
                fs_last = cyc;
            end
            hs_prev = a_hsync;
            vs_prev = a_vsync;
        end
        vectors++;
        if (vs_runs < 1 || fs_periods < 1) begin
            miscompares++;
            $display("[TB] FAIL sync_events_seen: got %0d/%0d, expected at least 1/1", vs_runs, fs_periods);
        end
    endtask

    task automatic test_reset_mid_frame();
        int target;
        bit found;
        for (int round = 0; round < 2; round++) begin
            target = (round == 0) ? (3 * H_TOT + 300) : int'($urandom_range(LAT_B + 1, FRAME - 1));
            found = 1'b0;
            for (int i = 0; i < FRAME + 10 && !found; i++) begin
                @(negedge clock);
                if (cyc % FRAME == target) found = 1'b1;
            end
            vectors++;
            if (!found) begin
                miscompares++;
                $display("[TB] FAIL midreset_position%0d: got 0, expected 1", round);
            end
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            vectors++;
            if ({a_addr, a_rd_en, a_rgb, a_hsync, a_vsync, a_fs, b_addr, b_rd_en, b_rgb, b_hsync, b_vsync, b_fs} !==
                {17'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 17'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL midreset_values%0d: got %h/%h, expected reset values", round,
                         {a_addr, a_rd_en, a_rgb, a_hsync, a_vsync, a_fs}, {b_addr, b_rd_en, b_rgb, b_hsync, b_vsync, b_fs});
            end
            for (int i = 0; i < H_TOT; i++) begin
                @(negedge clock);
                vectors++;
                if ({a_rgb, a_fs, a_hsync, b_rgb, b_fs, b_hsync} !==
                    {rgb_at(cyc - LAT_A), fs_at(cyc - LAT_A), hs_at(cyc - LAT_A), rgb_at(cyc - LAT_B), fs_at(cyc - LAT_B), hs_at(cyc - LAT_B)}) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_restart @%0d: got %h, expected %h", cyc, {a_rgb, a_fs, a_hsync, b_rgb, b_fs, b_hsync},
                             {rgb_at(cyc - LAT_A), fs_at(cyc - LAT_A), hs_at(cyc - LAT_A), rgb_at(cyc - LAT_B), fs_at(cyc - LAT_B), hs_at(cyc - LAT_B)});
                end
            end
        end
    endtask

    task automatic test_blanking();
        int sevens = 0;
        force_white = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clock);
            if (a_rgb == 3'd7) sevens++;
            vectors++;
            if (a_rgb !== (vis_at(cyc - LAT_A) ? 3'd7 : 3'd0)) begin
                miscompares++;
                $display("[TB] FAIL blank_a @%0d: got %0d, expected %0d", cyc, a_rgb, vis_at(cyc - LAT_A) ? 7 : 0);
            end
            vectors++;
            if (b_rgb !== (vis_at(cyc - LAT_B) ? 3'd7 : 3'd0)) begin
                miscompares++;
                $display("[TB] FAIL blank_b @%0d: got %0d, expected %0d", cyc, b_rgb, vis_at(cyc - LAT_B) ? 7 : 0);
            end
        end
        vectors++;
        if (sevens !== 640 * V_ACT) begin
            miscompares++;
            $display("[TB] FAIL blank_visible_count: got %0d, expected %0d", sevens, 640 * V_ACT);
        end
    endtask

    initial begin
        for (int i = 0; i < 76800; i++) mem[i] = 3'(i % 8);
        test_reset();
        test_first_line();
        test_full_frame();
        test_rd_latency3();
        test_sync_widths();
        test_reset_mid_frame();
        test_blanking();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
